vga_sync_rx: RTL

Receive-side companion to the VGA timing generator: samples `hsync_in`/`vsync_in` from a source on the same pixel clock and recovers pixel coordinates `hc`/`vc`. It measures line length and frame height, runs a lock state machine, and regenerates `vidon` once the timing is stable. It sits between a looped-back or external sync source and the display/capture logic that needs coordinates.

---
 rtl/vga_sync_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vga_sync_rx.sv
// Recovers hc/vc from an incoming hsync/vsync pair, measures line/frame size and tracks lock.
// Optional VGA_RX_STATS_EN adds a saturating err_cnt output.
module vga_sync_rx #(
  parameter int HSW = 96,
  parameter int HBP = 144,
  parameter int HFP = 784,
  parameter int VBP = 31,
  parameter int VFP = 511
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       vidon,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       locked,
  output logic       err
`ifdef VGA_RX_STATS_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [9:0] SAT   = 10'h3FF;
  localparam logic [9:0] HSW_L = 10'(HSW);
  localparam logic [9:0] HBP_L = 10'(HBP);
  localparam logic [9:0] HFP_L = 10'(HFP);
  localparam logic [9:0] VBP_L = 10'(VBP);
  localparam logic [9:0] VFP_L = 10'(VFP);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  state_t     state, state_nxt;
  logic       hs_s, vs_s, hs_p, vs_p;
  logic       ls, fs;
  logic [9:0] cur_len, line_cnt, ref_len, ref_frames;
  logic       have_ref, pending, pending_nxt;
  logic       len_bad, frame_bad, sat, lose;
  logic [9:0] hc_nxt, vc_nxt;
  logic       vidon_nxt;

  assign ls        = !hs_s && hs_p;
  assign fs        = !vs_s && vs_p;
  assign cur_len   = hc + 10'd1;
  assign len_bad   = ls && (cur_len != ref_len);
  assign frame_bad = fs && (line_cnt != ref_frames);
  assign sat       = (hc == SAT) || (vc == SAT);

  always_ff @(posedge clk) begin
    if (!clr_n) state <= SEARCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lose      = 1'b0;
    case (state)
      SEARCH:  if (fs) state_nxt = MEASURE;
      MEASURE: begin
        if (ls && have_ref && (cur_len != ref_len)) state_nxt = SEARCH;
        else if (fs)                                 state_nxt = VERIFY;
      end
      VERIFY: begin
        if (len_bad || frame_bad || sat) state_nxt = SEARCH;
        else if (fs)                     state_nxt = LOCKED;
      end
      LOCKED: begin
        if (len_bad || frame_bad || sat) begin
          state_nxt = SEARCH;
          lose      = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  // A frame start coinciding with a line start counts as inside the alignment window.
  always_comb begin
    hc_nxt      = (hc == SAT) ? hc : hc + 10'd1;
    vc_nxt      = vc;
    pending_nxt = pending;
    if (ls) hc_nxt = '0;
    if (fs && (ls || (hc < HSW_L))) begin
      vc_nxt      = '0;
      pending_nxt = 1'b0;
    end else begin
      if (ls) begin
        if (pending) begin
          vc_nxt      = '0;
          pending_nxt = 1'b0;
        end else if (vc != SAT) begin
          vc_nxt = vc + 10'd1;
        end
      end
      if (fs) pending_nxt = 1'b1;
    end
    vidon_nxt = (state_nxt == LOCKED) && (hc_nxt > HBP_L) && (hc_nxt < HFP_L) &&
                (vc_nxt > VBP_L) && (vc_nxt < VFP_L);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      hs_s <= 1'b1;  vs_s <= 1'b1;
      hs_p <= 1'b1;  vs_p <= 1'b1;
      hc <= '0;  vc <= '0;  vidon <= 1'b0;  pending <= 1'b0;
      line_len <= '0;  frame_lines <= '0;  line_cnt <= '0;  err <= 1'b0;
    end else begin
      hs_s <= hsync_in;  vs_s <= vsync_in;
      hs_p <= hs_s;      vs_p <= vs_s;
      hc <= hc_nxt;  vc <= vc_nxt;  vidon <= vidon_nxt;  pending <= pending_nxt;
      err <= lose;
      if (ls) line_len <= cur_len;
      if (fs) begin
        frame_lines <= line_cnt;
        line_cnt    <= ls ? 10'd1 : 10'd0;
      end else if (ls && (line_cnt != SAT)) begin
        line_cnt <= line_cnt + 10'd1;
      end
    end
  end

  // Reference capture: first line length after entering MEASURE, frame height at its end.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      have_ref   <= 1'b0;
      ref_len    <= '0;
      ref_frames <= '0;
    end else begin
      if (state == SEARCH && fs) begin
        have_ref <= 1'b0;
      end else if (state == MEASURE && ls && !have_ref) begin
        ref_len  <= cur_len;
        have_ref <= 1'b1;
      end
      if (state == MEASURE && fs) ref_frames <= line_cnt;
    end
  end

`ifdef VGA_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (!clr_n)                      err_cnt <= '0;
    else if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
